// File: rtl/sio_rsp_pkg.sv
// Shared types and default sizing for the L2 -> SIO response scheduler.
package sio_rsp_pkg;

  localparam int NUM_BANKS_DEF = 8;
  localparam int DATA_W_DEF    = 32;
  localparam int PAR_W_DEF     = 2;
  localparam int RD_BEATS_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arb #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      // Extra bit on sum so the wrap works for non power-of-two N too.
      sum = {1'b0, ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/l2_sio_rsp_sched.sv
// Round-robin scheduler of L2 bank response packets onto the single SIO return channel.
module l2_sio_rsp_sched
  import sio_rsp_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PAR_W     = PAR_W_DEF,
  parameter int RD_BEATS  = RD_BEATS_DEF,
  parameter int IW        = $clog2(NUM_BANKS)
) (
  input  logic                          iol2clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          bank_req,
  input  logic [NUM_BANKS-1:0]          bank_req_rd,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_data,
  input  logic [NUM_BANKS*PAR_W-1:0]    bank_parity,
  input  logic [NUM_BANKS-1:0]          bank_ue_err,
  input  logic                          sio_stall,
  output logic [NUM_BANKS-1:0]          bank_pop,
  output logic                          sio_ctag_vld,
  output logic [DATA_W-1:0]             sio_data,
  output logic [PAR_W-1:0]              sio_parity,
  output logic                          sio_ue_err,
  output logic                          busy,
  output state_e                        dbg_state,
  output logic [IW-1:0]                 dbg_rr_ptr
);

  localparam int CW = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;

  // Handshake: a bank holds bank_req (and its current beat) until it sees its
  // bank_pop bit on a clock edge; each pop consumes exactly one beat, and the
  // bank presents the next beat in the following cycle.

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          is_rd_q, is_rd_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          err_acc_q, err_acc_d;
  logic          bubble_q, bubble_d;

  logic              ctag_q, ctag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PAR_W-1:0]  par_q, par_d;
  logic              ue_q, ue_d;

  logic [NUM_BANKS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic [NUM_BANKS-1:0] gnt_dec;
  logic [DATA_W-1:0]    sel_data;
  logic [PAR_W-1:0]     sel_par;
  logic                 sel_ue;
  logic                 pop_en;

  rr_arb #(.N(NUM_BANKS), .IW(IW)) u_arb (
    .req (bank_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    gnt_dec  = '0;
    sel_data = '0;
    sel_par  = '0;
    sel_ue   = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant_q == IW'(b)) begin
        gnt_dec[b] = 1'b1;
        sel_data   = bank_data[b*DATA_W +: DATA_W];
        sel_par    = bank_parity[b*PAR_W +: PAR_W];
        sel_ue     = bank_ue_err[b];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    is_rd_d    = is_rd_q;
    beat_cnt_d = beat_cnt_q;
    err_acc_d  = err_acc_q;
    bubble_d   = bubble_q;
    ctag_d     = 1'b0;
    data_d     = data_q;
    par_d      = par_q;
    ue_d       = 1'b0;
    pop_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // One dead cycle after every packet before the next grant.
        if (bubble_q) begin
          bubble_d = 1'b0;
        end else if (|bank_req && !sio_stall) begin
          grant_d  = arb_idx;
          is_rd_d  = |(bank_req_rd & arb_gnt);
          rr_ptr_d = (arb_idx == IW'(NUM_BANKS-1)) ? '0 : arb_idx + 1'b1;
          state_d  = HDR;
        end
      end
      HDR: begin
        pop_en     = 1'b1;
        ctag_d     = 1'b1;
        data_d     = sel_data;
        par_d      = sel_par;
        err_acc_d  = sel_ue;
        beat_cnt_d = '0;
        if (is_rd_q) begin
          state_d = DATA;
        end else begin
          ue_d     = sel_ue;
          bubble_d = 1'b1;
          state_d  = IDLE;
        end
      end
      DATA: begin
        pop_en     = 1'b1;
        data_d     = sel_data;
        par_d      = sel_par;
        err_acc_d  = err_acc_q | sel_ue;
        beat_cnt_d = beat_cnt_q + 1'b1;
        if (beat_cnt_q == CW'(RD_BEATS-1)) begin
          ue_d       = err_acc_q | sel_ue;
          beat_cnt_d = '0;
          bubble_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      is_rd_q    <= 1'b0;
      beat_cnt_q <= '0;
      err_acc_q  <= 1'b0;
      bubble_q   <= 1'b0;
      ctag_q     <= 1'b0;
      data_q     <= '0;
      par_q      <= '0;
      ue_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      is_rd_q    <= is_rd_d;
      beat_cnt_q <= beat_cnt_d;
      err_acc_q  <= err_acc_d;
      bubble_q   <= bubble_d;
      ctag_q     <= ctag_d;
      data_q     <= data_d;
      par_q      <= par_d;
      ue_q       <= ue_d;
    end
  end

  assign bank_pop     = pop_en ? gnt_dec : '0;
  assign sio_ctag_vld = ctag_q;
  assign sio_data     = data_q;
  assign sio_parity   = par_q;
  assign sio_ue_err   = ue_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;
  assign dbg_rr_ptr   = rr_ptr_q;

endmodule
